quadrature_multi: RTL and testbench

Parametrised multi-channel quadrature encoder interface, the successor to the single-channel debounced 32-bit decoder.
- Per channel: input synchronisation, a glitch filter with a programmable stable-count, 4x decode into a WIDTH-bit wrapping counter, and sticky detection of illegal (double-edge) transitions.
- Adds per-channel clear, capture of the count on the index (Z) pulse, and a single-strobe coherent snapshot of all channels.
- Sits between encoder pins and the register/bus interface.

---
 rtl/quadrature_pkg.sv | 52 +++++
 rtl/quadrature_channel.sv | 125 ++++++++++++
 rtl/quadrature_multi.sv | 87 ++++++++
 tb/tb_quadrature_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quadrature_pkg.sv
// Shared definitions for the multi-channel quadrature decoder: A/B state encodings,
// the transition decoder and the supported parameter ranges.
package quadrature_pkg;

    // A/B phase states as {A, B}; forward order is 00 -> 10 -> 11 -> 01 -> 00
    localparam logic [1:0] Ab00 = 2'b00;
    localparam logic [1:0] Ab10 = 2'b10;
    localparam logic [1:0] Ab11 = 2'b11;
    localparam logic [1:0] Ab01 = 2'b01;

    localparam int unsigned MinChannels   = 1;
    localparam int unsigned MaxChannels   = 8;
    localparam int unsigned MinWidth      = 8;
    localparam int unsigned MaxWidth      = 32;
    localparam int unsigned MinSyncStages = 2;
    localparam int unsigned MaxSyncStages = 3;
    localparam int unsigned MinFilterLen  = 1;
    localparam int unsigned MaxFilterLen  = 15;

    typedef struct packed {
        logic inc;
        logic dec;
        logic illegal;
    } step_t;

    function automatic logic [1:0] fwd_next(input logic [1:0] ab);
        logic [1:0] nxt;
        unique case (ab)
            Ab00:    nxt = Ab10;
            Ab10:    nxt = Ab11;
            Ab11:    nxt = Ab01;
            default: nxt = Ab00;
        endcase
        return nxt;
    endfunction

    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        s = '0;
        if (prev != cur) begin
            if ((prev ^ cur) == 2'b11) begin
                s.illegal = 1'b1;
            end else if (fwd_next(prev) == cur) begin
                s.inc = 1'b1;
            end else begin
                s.dec = 1'b1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/quadrature_channel.sv
// One encoder channel: synchronisers and glitch filters for A/B/Z, 4x decode into a
// wrapping counter, sticky illegal-transition flag and index capture.
module quadrature_channel
    import quadrature_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             z_i,
    input  logic             clear_i,
    input  logic             settle_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] index_pos_o,
    output logic             index_seen_o,
    output logic             err_o
);

    localparam logic [3:0] FiltLast = 4'(FILTER_LEN - 1);

    // Signal index: 0 = A, 1 = B, 2 = Z
    logic [2:0]             pins;
    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [2:0]             synced;
    logic [2:0]             filt_q, filt_d;
    logic [3:0]             fcnt_q [3];
    logic [3:0]             fcnt_d [3];

    logic [1:0]       ab_prev_q;
    logic [1:0]       ab_cur;
    logic             z_prev_q;
    logic             z_rise;
    step_t            step;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] index_pos_q, index_pos_d;
    logic             index_seen_q, index_seen_d;
    logic             err_q, err_d;

    assign pins = {z_i, b_i, a_i};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (synced[i] != filt_q[i]) begin
                if (fcnt_q[i] == FiltLast) begin
                    filt_d[i] = synced[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    assign ab_cur = {filt_q[0], filt_q[1]};
    assign step   = decode_step(ab_prev_q, ab_cur);
    assign z_rise = filt_q[2] & ~z_prev_q & ~settle_i;

    always_comb begin
        count_d      = count_q;
        err_d        = err_q;
        index_seen_d = index_seen_q;
        index_pos_d  = index_pos_q;
        if (clear_i) begin
            count_d      = '0;
            err_d        = 1'b0;
            index_seen_d = 1'b0;
        end else begin
            if (!settle_i) begin
                if (step.inc) begin
                    count_d = count_q + WIDTH'(1);
                end else if (step.dec) begin
                    count_d = count_q - WIDTH'(1);
                end
                if (step.illegal) begin
                    err_d = 1'b1;
                end
            end
            // Index captures the count as it stands after this edge's step
            if (z_rise) begin
                index_pos_d  = count_d;
                index_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= '0;
                fcnt_q[i] <= '0;
            end
            filt_q       <= '0;
            ab_prev_q    <= '0;
            z_prev_q     <= 1'b0;
            count_q      <= '0;
            index_pos_q  <= '0;
            index_seen_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
                fcnt_q[i] <= fcnt_d[i];
            end
            filt_q       <= filt_d;
            ab_prev_q    <= ab_cur;
            z_prev_q     <= filt_q[2];
            count_q      <= count_d;
            index_pos_q  <= index_pos_d;
            index_seen_q <= index_seen_d;
            err_q        <= err_d;
        end
    end

    assign count_o      = count_q;
    assign index_pos_o  = index_pos_q;
    assign index_seen_o = index_seen_q;
    assign err_o        = err_q;

endmodule

// File: rtl/quadrature_multi.sv
// Multi-channel quadrature encoder interface: per-channel decoders plus a shared
// post-reset settle window and a coherent all-channel snapshot on LATCH.
module quadrature_multi
    import quadrature_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic [CHANNELS-1:0]       IN_A,
    input  logic [CHANNELS-1:0]       IN_B,
    input  logic [CHANNELS-1:0]       IN_Z,
    input  logic [CHANNELS-1:0]       CLEAR,
    input  logic                      LATCH,
    output logic [CHANNELS*WIDTH-1:0] COUNT,
    output logic [CHANNELS*WIDTH-1:0] SNAPSHOT,
    output logic [CHANNELS*WIDTH-1:0] INDEX_POS,
    output logic [CHANNELS-1:0]       INDEX_SEEN,
    output logic [CHANNELS-1:0]       ERR
);

    localparam bit ParamsOk =
        (CHANNELS >= MinChannels) && (CHANNELS <= MaxChannels) &&
        (WIDTH >= MinWidth) && (WIDTH <= MaxWidth) &&
        (SYNC_STAGES >= MinSyncStages) && (SYNC_STAGES <= MaxSyncStages) &&
        (FILTER_LEN >= MinFilterLen) && (FILTER_LEN <= MaxFilterLen);

    if (!ParamsOk) begin : gen_param_err
        $error("quadrature_multi: parameter out of supported range");
    end

    localparam int unsigned SettleLen = SYNC_STAGES + FILTER_LEN + 2;

    logic [4:0]                settle_q, settle_d;
    logic                      settle;
    logic [CHANNELS*WIDTH-1:0] snapshot_q, snapshot_d;

    assign settle = (settle_q != '0);

    always_comb begin
        settle_d   = settle_q;
        snapshot_d = snapshot_q;
        if (settle) begin
            settle_d = settle_q - 5'd1;
        end
        // Pre-update counts of every channel, so the snapshot is coherent
        if (LATCH) begin
            snapshot_d = COUNT;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            settle_q   <= 5'(SettleLen);
            snapshot_q <= '0;
        end else begin
            settle_q   <= settle_d;
            snapshot_q <= snapshot_d;
        end
    end

    assign SNAPSHOT = snapshot_q;

    for (genvar n = 0; n < CHANNELS; n++) begin : gen_chan
        quadrature_channel #(
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_chan (
            .CLK         (CLK),
            .RESETN      (RESETN),
            .a_i         (IN_A[n]),
            .b_i         (IN_B[n]),
            .z_i         (IN_Z[n]),
            .clear_i     (CLEAR[n]),
            .settle_i    (settle),
            .count_o     (COUNT[n*WIDTH +: WIDTH]),
            .index_pos_o (INDEX_POS[n*WIDTH +: WIDTH]),
            .index_seen_o(INDEX_SEEN[n]),
            .err_o       (ERR[n])
        );
    end

endmodule

// File: tb/tb_quadrature_multi.sv
// Self-checking bench for quadrature_multi: directed scenarios plus random stepping
// against a phase/position model of the encoder.
module tb_quadrature_multi;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [1:0]  IN_A, IN_B, IN_Z, CLEAR;
    logic        LATCH;
    logic [15:0] COUNT, SNAPSHOT, INDEX_POS;
    logic [1:0]  INDEX_SEEN, ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int ph[2];
    int exp_cnt[2];

    always #5 CLK = ~CLK;

    quadrature_multi #(
        .CHANNELS   (2),
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .FILTER_LEN (3)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_Z      (IN_Z),
        .CLEAR     (CLEAR),
        .LATCH     (LATCH),
        .COUNT     (COUNT),
        .SNAPSHOT  (SNAPSHOT),
        .INDEX_POS (INDEX_POS),
        .INDEX_SEEN(INDEX_SEEN),
        .ERR       (ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Encoder position within a cycle of four states, A leading B when moving forward
    function automatic int phase_of(input logic a, input logic b);
        return a ? (b ? 2 : 1) : (b ? 3 : 0);
    endfunction

    function automatic logic [15:0] exp_packed();
        logic [15:0] v;
        v[7:0]  = 8'(exp_cnt[0]);
        v[15:8] = 8'(exp_cnt[1]);
        return v;
    endfunction

    task automatic set_pins(input int ch);
        IN_A[ch] = (ph[ch] == 1) || (ph[ch] == 2);
        IN_B[ch] = (ph[ch] >= 2);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic drive_step(input int ch, input int dir);
        ph[ch]      = (ph[ch] + dir + 4) % 4;
        exp_cnt[ch] = (exp_cnt[ch] + dir) & 255;
        set_pins(ch);
    endtask

    task automatic step(input int ch, input int dir, input int gap);
        drive_step(ch, dir);
        tick(gap);
    endtask

    initial begin
        int          gdir;
        int          saved;
        logic [15:0] snap_exp;

        RESETN = 1'b0;
        LATCH  = 1'b0;
        CLEAR  = '0;
        IN_Z   = '0;
        IN_A   = '0;
        IN_B   = '0;
        ph[0] = 2; ph[1] = 2;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        set_pins(0);
        set_pins(1);
        tick(3);
        check("rst_count", COUNT, 0);
        check("rst_err", ERR, 0);
        check("rst_snapshot", SNAPSHOT, 0);
        check("rst_index_pos", INDEX_POS, 0);
        check("rst_index_seen", INDEX_SEEN, 0);

        RESETN = 1'b1;
        tick(12);
        check("settle_count", COUNT, 0);
        check("settle_err", ERR, 0);

        // First edge: visible after exactly 6 rising edges
        drive_step(0, 1);
        tick(5);
        check("latency_before", COUNT[7:0], 0);
        tick(1);
        check("latency_at", COUNT[7:0], 1);
        tick(2);
        for (int i = 0; i < 9; i++) step(0, 1, 8);
        check("forward_10", COUNT, exp_packed());
        check("forward_10_const", COUNT, 16'h000A);

        for (int i = 0; i < 11; i++) step(0, -1, 8);
        check("wrap_down", COUNT[7:0], 8'hFF);
        step(0, 1, 8);
        check("wrap_up", COUNT[7:0], 8'h00);

        // Glitch filter: 2-cycle pulse is dropped, 3-cycle pulse passes
        IN_A[0] = ~IN_A[0];
        tick(2);
        IN_A[0] = ~IN_A[0];
        tick(8);
        check("glitch2", COUNT, exp_packed());
        gdir = (((phase_of(~IN_A[0], IN_B[0]) - ph[0] + 4) % 4) == 1) ? 1 : -1;
        IN_A[0] = ~IN_A[0];
        tick(3);
        IN_A[0] = ~IN_A[0];
        tick(4);
        check("glitch3_step", COUNT[7:0], 32'((exp_cnt[0] + gdir) & 255));
        tick(6);
        check("glitch3_back", COUNT[7:0], 32'(exp_cnt[0]));
        check("glitch_err", ERR, 0);

        // Illegal 00 -> 11 jump
        step(0, 1, 8);
        step(0, 1, 8);
        IN_A[0] = 1'b1;
        IN_B[0] = 1'b1;
        ph[0]   = phase_of(1'b1, 1'b1);
        tick(8);
        check("illegal_err", ERR, 2'b01);
        check("illegal_count", COUNT, exp_packed());

        // CLEAR coincident with a count step
        drive_step(0, 1);
        tick(5);
        CLEAR[0] = 1'b1;
        tick(1);
        CLEAR[0] = 1'b0;
        exp_cnt[0] = 0;
        tick(3);
        check("clear_count", COUNT, exp_packed());
        check("clear_err", ERR, 0);

        // Index capture, then a Z edge coincident with a step
        for (int i = 0; i < 5; i++) step(0, 1, 8);
        IN_Z[0] = 1'b1;
        tick(8);
        check("index_pos_5", INDEX_POS[7:0], 5);
        check("index_seen", INDEX_SEEN, 2'b01);
        IN_Z[0] = 1'b0;
        tick(8);
        IN_Z[0] = 1'b1;
        drive_step(0, 1);
        tick(8);
        check("index_post_update", INDEX_POS[7:0], 32'(exp_cnt[0]));
        saved = exp_cnt[0];
        CLEAR[0] = 1'b1;
        tick(1);
        CLEAR[0] = 1'b0;
        exp_cnt[0] = 0;
        tick(1);
        check("clear_index_seen", INDEX_SEEN, 0);
        check("clear_index_hold", INDEX_POS[7:0], 32'(saved));

        // LATCH on the edge where ch1 goes 3 -> 4
        for (int i = 0; i < 3; i++) step(1, 1, 8);
        saved = exp_cnt[1];
        drive_step(1, 1);
        tick(5);
        LATCH = 1'b1;
        tick(1);
        LATCH = 1'b0;
        check("snapshot_ch1", SNAPSHOT[15:8], 3);
        check("snapshot_ch1_model", SNAPSHOT[15:8], 32'(saved));
        check("snapshot_ch0", SNAPSHOT[7:0], 32'(exp_cnt[0]));
        check("count_ch1_after", COUNT[15:8], 32'(exp_cnt[1]));
        tick(3);
        step(1, 1, 8);
        check("snapshot_hold", SNAPSHOT[15:8], 3);

        // Random stepping across both channels
        for (int i = 0; i < 30; i++) begin
            int ch;
            int dir;
            ch  = int'($urandom_range(0, 1));
            dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
            step(ch, dir, int'($urandom_range(7, 12)));
            check("rnd_count", COUNT, exp_packed());
            if ($urandom_range(0, 3) == 0) begin
                LATCH = 1'b1;
                tick(1);
                LATCH = 1'b0;
                check("rnd_snapshot", SNAPSHOT, exp_packed());
            end
        end

        // LATCH and CLEAR on the same edge
        snap_exp = exp_packed();
        LATCH = 1'b1;
        CLEAR = 2'b11;
        tick(1);
        LATCH = 1'b0;
        CLEAR = 2'b00;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        check("latch_clear_snapshot", SNAPSHOT, 32'(snap_exp));
        check("latch_clear_count", COUNT, 0);

        // Reset mid-operation with pins left wherever they are
        RESETN = 1'b0;
        tick(2);
        check("mid_rst_count", COUNT, 0);
        check("mid_rst_snapshot", SNAPSHOT, 0);
        check("mid_rst_index_pos", INDEX_POS, 0);
        RESETN = 1'b1;
        tick(12);
        check("mid_settle_count", COUNT, 0);
        check("mid_settle_err", ERR, 0);
        check("mid_settle_seen", INDEX_SEEN, 0);
        step(0, 1, 8);
        step(1, -1, 8);
        check("mid_step", COUNT, exp_packed());
        check("mid_step_const", COUNT, 16'hFF01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
